uart16750_bus_ctrl: RTL
=======================

// Module: uart16750_bus_ctrl
// PURPOSE
//  Register-bus sequencer for the uart_16750 core. After reset it programs the UART
//  (LCR/DLL/DLM/FCR/IER), then polls LSR. RBR bytes go to a one-entry rx stream port;
//  bytes from a tx stream port are written to THR.
//  Sits between the UART (clk_33M domain) and fabric consumers; replaces ad-hoc
//  per-design config/poll FSMs in top-level files.
// PARAMETERS
//  DIVISOR   16'h0011  baud divisor written to DLL (low byte) / DLM (high byte)
//  LCR_MODE  8'h03     line mode (8N1); DLAB write uses LCR_MODE|8'h80
//  FCR_VAL   8'h00     FIFO control value
//  IER_VAL   8'h01     interrupt enable value
// PORTS
//  clk        in   1  UART core clock
//  rst        in   1  synchronous, active-high reset
//  cfg_start  in   1  pulse: re-run the configuration sequence
//  cfg_done   out  1  high once configuration is complete
//  tx_valid   in   1  tx byte offered
//  tx_data    in   8  tx byte
//  tx_ready   out  1  one-cycle accept; byte transfers when tx_valid&tx_ready
//  rx_valid   out  1  rx holding register full
//  rx_data    out  8  rx byte, stable while rx_valid
//  rx_ready   in   1  consumer takes byte when rx_valid&rx_ready
//  lsr_err    out  4  sticky LSR[4:1] (BI,FE,PE,OE); OR-accumulated, cleared by rst/cfg_start
//  uart_cs    out  1  UART chip select
//  uart_wr    out  1  UART write strobe
//  uart_rd    out  1  UART read strobe
//  uart_addr  out  3  UART register address
//  uart_din   out  8  write data to UART
//  uart_dout  in   8  read data from UART
// BEHAVIOUR
//  Reset (clk edge with rst=1): all outputs 0, FSM=CFG_LCR_DLAB, rx holding empty,
//   priority toggle=RX. rst overrides any in-flight access (cs drops next cycle).
//  Access: 4 cycles, never truncated.
//   A0 cs=1, addr/din valid. A1,A2 cs=1 with wr or rd=1. A3 all low (turnaround).
//   Reads capture uart_dout at the end of A2.
//  Config FSM: CFG_LCR_DLAB -> CFG_DLL -> CFG_DLM -> CFG_LCR -> CFG_FCR -> CFG_IER -> POLL.
//   - One write per state; 24 cycles in total.
//   - cfg_done rises in the cycle after CFG_IER's A3 (cycle 25 after rst release)
//     and stays high until rst or cfg_start.
//  cfg_start: cfg_done falls next cycle and lsr_err is cleared.
//   - If an access is in flight, it completes; CFG_LCR_DLAB then begins.
//   - rx holding contents are kept.
//   - cfg_start during config restarts config after the current access.
//  POLL: read LSR (addr 5), then DECIDE (1 cycle, bus idle).
//   - rx_ok = LSR[0] & holding empty. tx_ok = LSR[5] & tx_valid.
//   - Both set: serve the toggle's side, then flip the toggle. One set: serve it.
//     Neither: return to POLL.
//   - RX service: read RBR (addr 0). rx_valid rises the cycle after A2; rx_data = captured byte.
//   - TX service: tx_ready=1 in DECIDE; tx_data registered into uart_din; THR write follows.
//   - At most one THR write per LSR read.
//  Holding full: RBR is not read. The UART overruns; its OE appears in lsr_err.
//  rx_ready with rx_valid=0 is ignored.
//  tx_ready is never asserted before cfg_done or outside DECIDE.
//  tx_valid may drop without acceptance; tx_data must be stable only in the accept cycle.
//  Before cfg_done, rx/tx ports are inactive.
// STRUCTURE
//  Package uart16750_pkg:
//   - register addresses (RBR/THR=0, IER=1, FCR=2, LCR=3, MCR=4, LSR=5, MSR=6, SCR=7; DLL=0, DLM=1)
//   - LSR masks (DR=8'h01, ERR=8'h1E, THRE=8'h20), DLAB=8'h80
//   - ctrl state enum
//  Sub-module uart16750_bus_access implements the A0-A3 access.
//   - Ports: start, we, addr, wdata -> busy, done (pulse in A3), rdata.
//   - The top FSM issues accesses and arbitrates.
// TESTING
//  1. rst released: writes LCR=83,DLL=11,DLM=00,LCR=03,FCR=00,IER=01 in order, 4 cycles each;
//     cfg_done at cycle 25.
//  2. Model LSR=21, RBR=41, rx_ready=0: one RBR read, then rx_valid=1, rx_data=41.
//     Further LSR=21 causes no RBR read until rx_ready accepts.
//  3. tx_valid=1, tx_data=5A, LSR=20: tx_ready one cycle, then THR write din=5A.
//     LSR=00 gives tx_ready=0.
//  4. LSR=21 continuously, tx_valid=1, rx_ready=1: services alternate RX,TX,RX,TX.
//  5. LSR=03 then 09: lsr_err=4'b0101. cfg_start clears it and re-runs the config writes.
//  6. rst asserted in A1 of an RBR read: next cycle cs/rd/rx_valid=0.
//     Config restarts cleanly after release.

Source files
------------

// File: rtl/uart16750_pkg.sv
// uart16750_pkg: register map, LSR bit masks and sequencer states for the 16750 bus controller
package uart16750_pkg;
  localparam logic [2:0] REG_RBR = 3'd0, REG_THR = 3'd0, REG_IER = 3'd1, REG_FCR = 3'd2;
  localparam logic [2:0] REG_LCR = 3'd3, REG_MCR = 3'd4, REG_LSR = 3'd5, REG_MSR = 3'd6;
  localparam logic [2:0] REG_SCR = 3'd7, REG_DLL = 3'd0, REG_DLM = 3'd1;
  localparam logic [7:0] LSR_DR = 8'h01, LSR_ERR = 8'h1E, LSR_THRE = 8'h20, LCR_DLAB = 8'h80;
  typedef enum logic [3:0] {
    CFG_LCR_DLAB, CFG_DLL, CFG_DLM, CFG_LCR, CFG_FCR, CFG_IER, POLL, DECIDE, RX_RD, TX_WR
  } ctrl_state_t;
endpackage

// File: rtl/uart16750_bus_access.sv
// uart16750_bus_access: one 4-cycle UART register access (A0 setup, A1-A2 strobe, A3 turnaround)
module uart16750_bus_access (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       we,
  input  logic [2:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       uart_cs,
  output logic       uart_wr,
  output logic       uart_rd,
  output logic [2:0] uart_addr,
  output logic [7:0] uart_din,
  input  logic [7:0] uart_dout
);
  logic       act, we_r;
  logic [1:0] ph;
  always_ff @(posedge clk) begin
    if (rst) begin
      act       <= 1'b0;
      we_r      <= 1'b0;
      ph        <= 2'd0;
      uart_addr <= 3'd0;
      uart_din  <= 8'h00;
      rdata     <= 8'h00;
    end else begin
      if (start) begin
        act       <= 1'b1;
        ph        <= 2'd0;
        we_r      <= we;
        uart_addr <= addr;
        uart_din  <= wdata;
      end else if (act) begin
        ph  <= ph + 2'd1;
        act <= ph != 2'd3;
      end
      if (act && !we_r && ph == 2'd2) rdata <= uart_dout;
    end
  end
  // A new start is taken in A3 so accesses run back to back without a gap
  always_comb begin
    busy    = act && ph != 2'd3;
    done    = act && ph == 2'd3;
    uart_cs = busy;
    uart_wr = act && we_r && (ph == 2'd1 || ph == 2'd2);
    uart_rd = act && !we_r && (ph == 2'd1 || ph == 2'd2);
  end
endmodule

// File: rtl/uart16750_bus_ctrl.sv
// uart16750_bus_ctrl: programs the UART after reset, then polls LSR and moves bytes between RBR/THR and stream ports
module uart16750_bus_ctrl
  import uart16750_pkg::*;
#(
  parameter logic [15:0] DIVISOR  = 16'h0011,
  parameter logic [7:0]  LCR_MODE = 8'h03,
  parameter logic [7:0]  FCR_VAL  = 8'h00,
  parameter logic [7:0]  IER_VAL  = 8'h01
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_start,
  output logic       cfg_done,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  input  logic       rx_ready,
  output logic [3:0] lsr_err,
  output logic       uart_cs,
  output logic       uart_wr,
  output logic       uart_rd,
  output logic [2:0] uart_addr,
  output logic [7:0] uart_din,
  input  logic [7:0] uart_dout
);
  ctrl_state_t state, nxt;
  logic       tog, hold_full, rq, restart, start, we, busy, done;
  logic       rx_ok, tx_ok, serve_rx, serve_tx, rx_fill, rx_take;
  logic [2:0] addr;
  logic [7:0] wdata, rdata, hold, err_bits;
  uart16750_bus_access u_acc (
    .clk(clk), .rst(rst), .start(start), .we(we), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .rdata(rdata),
    .uart_cs(uart_cs), .uart_wr(uart_wr), .uart_rd(uart_rd),
    .uart_addr(uart_addr), .uart_din(uart_din), .uart_dout(uart_dout)
  );
  // rdata still holds the last LSR value while in DECIDE
  always_comb begin
    restart  = (cfg_start || rq) && !busy;
    rx_ok    = |(rdata & LSR_DR) && !hold_full;
    tx_ok    = |(rdata & LSR_THRE) && tx_valid;
    serve_rx = rx_ok && (!tx_ok || !tog);
    serve_tx = tx_ok && !serve_rx;
    nxt      = state;
    if (restart) nxt = CFG_LCR_DLAB;
    else if (done || state == DECIDE)
      case (state)
        CFG_LCR_DLAB: nxt = CFG_DLL;
        CFG_DLL:      nxt = CFG_DLM;
        CFG_DLM:      nxt = CFG_LCR;
        CFG_LCR:      nxt = CFG_FCR;
        CFG_FCR:      nxt = CFG_IER;
        POLL:         nxt = DECIDE;
        DECIDE:       nxt = serve_rx ? RX_RD : serve_tx ? TX_WR : POLL;
        default:      nxt = POLL;
      endcase
    start = nxt != DECIDE && !busy;
    we    = !(nxt inside {POLL, RX_RD});
    case (nxt)
      CFG_LCR_DLAB: {addr, wdata} = {REG_LCR, LCR_MODE | LCR_DLAB};
      CFG_DLL:      {addr, wdata} = {REG_DLL, DIVISOR[7:0]};
      CFG_DLM:      {addr, wdata} = {REG_DLM, DIVISOR[15:8]};
      CFG_LCR:      {addr, wdata} = {REG_LCR, LCR_MODE};
      CFG_FCR:      {addr, wdata} = {REG_FCR, FCR_VAL};
      CFG_IER:      {addr, wdata} = {REG_IER, IER_VAL};
      POLL:         {addr, wdata} = {REG_LSR, 8'h00};
      TX_WR:        {addr, wdata} = {REG_THR, tx_data};
      default:      {addr, wdata} = {REG_RBR, 8'h00};
    endcase
    tx_ready = state == DECIDE && !restart && serve_tx;
    rx_fill  = state == RX_RD && done;
    rx_valid = hold_full || rx_fill;
    rx_data  = hold_full ? hold : rdata;
    rx_take  = rx_valid && rx_ready;
    err_bits = (state == POLL && done) ? (rdata & LSR_ERR) : 8'h00;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= CFG_LCR_DLAB;
      tog       <= 1'b0;
      hold_full <= 1'b0;
      hold      <= 8'h00;
      rq        <= 1'b0;
      cfg_done  <= 1'b0;
      lsr_err   <= 4'h0;
    end else begin
      state     <= nxt;
      rq        <= (cfg_start || rq) && busy;
      cfg_done  <= !cfg_start && (cfg_done || (state == CFG_IER && nxt == POLL));
      lsr_err   <= cfg_start ? 4'h0 : lsr_err | err_bits[4:1];
      tog       <= (state == DECIDE && !restart && rx_ok && tx_ok) ? !tog : tog;
      hold_full <= !rx_take && (hold_full || rx_fill);
      hold      <= rx_fill ? rdata : hold;
    end
  end
endmodule
